// File: rtl/cp0_exc_ctrl.sv
// Exception/ERET commit sequencer: prioritises the committing instruction's cause, drains the data bus,
// strobes CP0, then redirects fetch (strobe at N+1, redirect at N+2 when not busy). Optional TLB causes: CP0_EXC_TLB_EN.
module cp0_exc_ctrl #(
  parameter int DRAIN_MAX = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [9:0]  mem_exc,
  input  logic        mem_store,
  input  logic        mem_tlb_mod,
  input  logic [31:0] mem_dvaddr,
  input  logic        mem_eret,
  input  logic        mem_busy,
  input  logic        interrupt_pending,
  input  logic [31:0] exc_handler,
  input  logic [31:0] int_handler,
  input  logic [31:0] tlb_refill_handler,
  input  logic [31:0] epc,
  output logic        en_exp_o,
  output logic        exp_bd,
  output logic [31:0] exp_epc,
  output logic [4:0]  exp_excCode,
  output logic [31:0] exp_badVAddr,
  output logic        exp_badVAddr_we,
  output logic        clear_exl,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  localparam int CW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(DRAIN_MAX);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DRAIN    = 2'd1;
  localparam logic [1:0] S_COMMIT   = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [1:0] K_INT    = 2'd0;
  localparam logic [1:0] K_EXC    = 2'd1;
  localparam logic [1:0] K_REFILL = 2'd2;
  localparam logic [1:0] K_ERET   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          to_set;

  logic [1:0]  kind_q;
  logic        bd_q;
  logic [31:0] epc_q;
  logic [4:0]  code_q;
  logic [31:0] badv_q;
  logic        badv_we_q;

  logic        en_exp_q, clear_exl_q, stall_q, flush_q, redirect_valid_q, timeout_q;
  logic [31:0] redirect_pc_q;

  logic [9:0]  exc_m;
  logic        event_w;
  logic [1:0]  kind_w;
  logic [4:0]  code_w;
  logic [31:0] badv_w;
  logic        badv_we_w;
  logic        is_eret_d;
  logic [31:0] target_w;

`ifdef CP0_EXC_TLB_EN
  assign exc_m = mem_exc;
`else
  // TLB-originated causes (bits 1, 2, 8, 9) do not exist in this build.
  assign exc_m = mem_exc & 10'b00_1111_1001;
`endif

  assign event_w = mem_valid && (interrupt_pending || (|exc_m) || mem_eret);

  always_comb begin
    kind_w    = K_EXC;
    code_w    = 5'd0;
    badv_w    = 32'd0;
    badv_we_w = 1'b0;
    if (interrupt_pending) begin
      kind_w = K_INT;
    end else if (exc_m[0]) begin
      code_w    = 5'd4;
      badv_w    = mem_pc;
      badv_we_w = 1'b1;
    end else if (exc_m[1]) begin
      kind_w    = K_REFILL;
      code_w    = 5'd2;
      badv_w    = mem_pc;
      badv_we_w = 1'b1;
    end else if (exc_m[2]) begin
      code_w    = 5'd2;
      badv_w    = mem_pc;
      badv_we_w = 1'b1;
    end else if (exc_m[3]) begin
      code_w = 5'd10;
    end else if (exc_m[4]) begin
      code_w = 5'd12;
    end else if (exc_m[5]) begin
      code_w = 5'd8;
    end else if (exc_m[6]) begin
      code_w = 5'd9;
    end else if (exc_m[7]) begin
      code_w    = mem_store ? 5'd5 : 5'd4;
      badv_w    = mem_dvaddr;
      badv_we_w = 1'b1;
    end else if (exc_m[8]) begin
      kind_w    = K_REFILL;
      code_w    = mem_store ? 5'd3 : 5'd2;
      badv_w    = mem_dvaddr;
      badv_we_w = 1'b1;
    end else if (exc_m[9]) begin
      code_w    = mem_tlb_mod ? 5'd1 : (mem_store ? 5'd3 : 5'd2);
      badv_w    = mem_dvaddr;
      badv_we_w = 1'b1;
    end else if (mem_eret) begin
      kind_w = K_ERET;
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (event_w) state_d = mem_busy ? S_DRAIN : S_COMMIT;
      end
      S_DRAIN: begin
        if (!mem_busy) begin
          state_d = S_COMMIT;
          cnt_d   = '0;
        end else if (cnt_inc >= LIMIT) begin
          state_d = S_COMMIT;
          cnt_d   = '0;
          to_set  = 1'b1;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      S_COMMIT:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // A direct IDLE->COMMIT jump has not captured the kind yet, so look at the live decode.
  assign is_eret_d = (state_q == S_IDLE) ? (kind_w == K_ERET) : (kind_q == K_ERET);

  always_comb begin
    case (kind_q)
      K_INT:    target_w = int_handler;
      K_REFILL: target_w = tlb_refill_handler;
      K_ERET:   target_w = epc;
      default:  target_w = exc_handler;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      kind_q           <= K_INT;
      bd_q             <= 1'b0;
      epc_q            <= 32'd0;
      code_q           <= 5'd0;
      badv_q           <= 32'd0;
      badv_we_q        <= 1'b0;
      en_exp_q         <= 1'b0;
      clear_exl_q      <= 1'b0;
      stall_q          <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      timeout_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && event_w) begin
        kind_q    <= kind_w;
        bd_q      <= mem_bd;
        epc_q     <= mem_bd ? (mem_pc - 32'd4) : mem_pc;
        code_q    <= code_w;
        badv_q    <= badv_w;
        badv_we_q <= badv_we_w;
      end
      en_exp_q         <= (state_d == S_COMMIT) && !is_eret_d;
      clear_exl_q      <= (state_d == S_COMMIT) && is_eret_d;
      stall_q          <= (state_d != S_IDLE);
      flush_q          <= (state_d == S_COMMIT) || (state_d == S_REDIRECT);
      redirect_valid_q <= (state_d == S_REDIRECT);
      // Sample the handler now, before CP0 reacts to the strobe.
      if (state_q == S_COMMIT) redirect_pc_q <= target_w;
      if (to_set) timeout_q <= 1'b1;
    end
  end

  assign en_exp_o        = en_exp_q;
  assign exp_bd          = bd_q;
  assign exp_epc         = epc_q;
  assign exp_excCode     = code_q;
  assign exp_badVAddr    = badv_q;
  assign exp_badVAddr_we = badv_we_q;
  assign clear_exl       = clear_exl_q;
  assign stall           = stall_q;
  assign flush           = flush_q | ((state_q == S_IDLE) && event_w);
  assign redirect_valid  = redirect_valid_q;
  assign redirect_pc     = redirect_pc_q;
  assign drain_timeout   = timeout_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed cases then random transactions, each checked cycle by cycle
// against a cause/priority model and an arithmetic prediction of the drain length.
module tb_cp0_exc_ctrl;

  localparam int DMAX = 4;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [9:0]  mem_exc;
  logic        mem_store;
  logic        mem_tlb_mod;
  logic [31:0] mem_dvaddr;
  logic        mem_eret;
  logic        mem_busy;
  logic        interrupt_pending;
  logic [31:0] exc_handler, int_handler, tlb_refill_handler, epc;
  logic        en_exp_o, exp_bd, exp_badVAddr_we, clear_exl, stall, flush;
  logic        redirect_valid, drain_timeout;
  logic [31:0] exp_epc, exp_badVAddr, redirect_pc;
  logic [4:0]  exp_excCode;

  int n_cmp = 0;
  int n_fail = 0;
  bit tout_model = 0;

  cp0_exc_ctrl #(.DRAIN_MAX(DMAX)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
    .mem_exc(mem_exc), .mem_store(mem_store), .mem_tlb_mod(mem_tlb_mod), .mem_dvaddr(mem_dvaddr),
    .mem_eret(mem_eret), .mem_busy(mem_busy), .interrupt_pending(interrupt_pending),
    .exc_handler(exc_handler), .int_handler(int_handler), .tlb_refill_handler(tlb_refill_handler),
    .epc(epc), .en_exp_o(en_exp_o), .exp_bd(exp_bd), .exp_epc(exp_epc), .exp_excCode(exp_excCode),
    .exp_badVAddr(exp_badVAddr), .exp_badVAddr_we(exp_badVAddr_we), .clear_exl(clear_exl),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .drain_timeout(drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 interrupt, 1 general exception, 2 TLB refill, 3 ERET
  typedef struct packed {
    bit        ev;
    bit [1:0]  kind;
    bit [4:0]  code;
    bit [31:0] epc;
    bit [31:0] badv;
    bit        we;
  } exp_t;

  function automatic exp_t model(input bit valid, input bit [31:0] pc, input bit bd,
                                 input bit [9:0] exc, input bit store, input bit tmod,
                                 input bit [31:0] dva, input bit eret, input bit intp);
    exp_t r;
    bit [9:0] m;
    int codes [10];
    int b;
    codes = '{4, 2, 2, 10, 12, 8, 9, 4, 2, 2};
    m = exc;
`ifndef CP0_EXC_TLB_EN
    m[1] = 1'b0; m[2] = 1'b0; m[8] = 1'b0; m[9] = 1'b0;
`endif
    r = '0;
    r.epc = bd ? pc - 32'd4 : pc;
    r.ev = valid && (intp || m != 0 || eret);
    if (intp) begin
      r.kind = 2'd0;
    end else if (m != 0) begin
      b = 0;
      while (!m[b]) b++;
      r.code = 5'(codes[b]);
      if (b >= 7 && store) r.code = r.code + 5'd1;
      if (b == 9 && tmod) r.code = 5'd1;
      r.we = (b <= 2) || (b >= 7);
      r.badv = !r.we ? 32'd0 : (b <= 2 ? pc : dva);
      r.kind = (b == 1 || b == 8) ? 2'd2 : 2'd1;
    end else begin
      r.kind = 2'd3;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic txn(input bit valid, input bit [31:0] pc, input bit bd, input bit [9:0] exc,
                     input bit store, input bit tmod, input bit [31:0] dva, input bit eret,
                     input bit intp, input int busy_cycles);
    exp_t e;
    int dm, c;
    bit [31:0] tgt;
    e = model(valid, pc, bd, exc, store, tmod, dva, eret, intp);
    case (e.kind)
      2'd0:    tgt = int_handler;
      2'd2:    tgt = tlb_refill_handler;
      2'd3:    tgt = epc;
      default: tgt = exc_handler;
    endcase
    @(negedge clk);
    mem_valid = valid; mem_pc = pc; mem_bd = bd; mem_exc = exc; mem_store = store;
    mem_tlb_mod = tmod; mem_dvaddr = dva; mem_eret = eret; interrupt_pending = intp;
    mem_busy = (busy_cycles > 0);
    #1;
    chk("event_flush", flush, 32'(e.ev));
    chk("event_stall", stall, 0);
    if (!e.ev) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        if (k == 1) mem_valid = 1'b0;
        #1;
        chk("noev_stall", stall, 0);
        chk("noev_strobe", {en_exp_o, clear_exl, redirect_valid}, 0);
      end
      return;
    end
    dm = (DMAX < 1) ? 1 : DMAX;
    c = 1 + ((busy_cycles == 0) ? 0 : (busy_cycles < dm ? busy_cycles : dm));
    if (busy_cycles > dm) tout_model = 1'b1;
    for (int k = 1; k <= c + 2; k++) begin
      @(negedge clk);
      mem_busy = (k < busy_cycles);
      if (k == c + 1) mem_valid = 1'b0;
      #1;
      if (k < c) begin
        chk("drain_stall", stall, 1);
        chk("drain_quiet", {flush, en_exp_o, clear_exl, redirect_valid}, 0);
      end else if (k == c) begin
        chk("commit_stall_flush", {stall, flush}, 2'b11);
        chk("commit_en_exp", en_exp_o, 32'(e.kind != 2'd3));
        chk("commit_clear_exl", clear_exl, 32'(e.kind == 2'd3));
        chk("commit_redirect", redirect_valid, 0);
        chk("commit_timeout", drain_timeout, 32'(tout_model));
        if (e.kind != 2'd3) begin
          chk("exp_code", exp_excCode, 32'(e.code));
          chk("exp_epc", exp_epc, e.epc);
          chk("exp_bd", exp_bd, 32'(bd));
          chk("exp_badv_we", exp_badVAddr_we, 32'(e.we));
          chk("exp_badv", exp_badVAddr, e.badv);
        end
      end else if (k == c + 1) begin
        chk("redir_stall_flush", {stall, flush}, 2'b11);
        chk("redir_valid", redirect_valid, 1);
        chk("redir_pc", redirect_pc, tgt);
        chk("redir_strobes", {en_exp_o, clear_exl}, 0);
      end else begin
        chk("idle_outputs", {stall, flush, redirect_valid, en_exp_o, clear_exl}, 0);
        chk("idle_timeout", drain_timeout, 32'(tout_model));
      end
    end
  endtask

  initial begin
    bit [31:0] r_pc, r_dva;
    bit [9:0]  r_exc;
    resetn = 1'b0;
    mem_valid = 0; mem_pc = 0; mem_bd = 0; mem_exc = 0; mem_store = 0; mem_tlb_mod = 0;
    mem_dvaddr = 0; mem_eret = 0; mem_busy = 0; interrupt_pending = 0;
    exc_handler = 32'h8000_0180; int_handler = 32'h8000_0200;
    tlb_refill_handler = 32'h8000_0000; epc = 32'h8000_3000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobes", {en_exp_o, clear_exl, redirect_valid, stall, flush, drain_timeout}, 0);
    chk("rst_fields", {exp_bd, exp_badVAddr_we, exp_excCode}, 0);
    chk("rst_epc", exp_epc, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Syscall, not busy
    txn(1, 32'h8000_1000, 0, 10'h020, 0, 0, 32'h0, 0, 0, 0);
    // Ov beats AdES, in a delay slot
    txn(1, 32'h8000_2004, 1, 10'h090, 1, 0, 32'h1234_5678, 0, 0, 0);
    // Data refill on a store with three busy cycles
    txn(1, 32'h8000_4000, 0, 10'h100, 1, 0, 32'h0040_0010, 0, 0, 3);
    // ERET, then ERET with a pending interrupt
    txn(1, 32'h8000_5000, 0, 10'h000, 0, 0, 32'h0, 1, 0, 0);
    txn(1, 32'h8000_5000, 0, 10'h000, 0, 0, 32'h0, 1, 1, 0);
    // Exception alongside ERET: RI wins
    txn(1, 32'h8000_6000, 0, 10'h008, 0, 0, 32'h0, 1, 0, 1);
    // AdEL-IF and a Mod store
    txn(1, 32'h8000_7001, 0, 10'h001, 0, 0, 32'h0, 0, 0, 2);
    txn(1, 32'h8000_7100, 0, 10'h200, 1, 1, 32'h0050_0000, 0, 0, 0);
    // Interrupt blocked by mem_valid=0
    txn(0, 32'h8000_8000, 0, 10'h000, 0, 0, 32'h0, 0, 1, 0);
    // Bus stuck busy: forced commit after DMAX drain cycles, flag stays set
    txn(1, 32'h8000_9000, 0, 10'h040, 0, 0, 32'h0, 0, 0, 50);
    txn(1, 32'h8000_9100, 0, 10'h010, 0, 0, 32'h0, 0, 0, 0);
    // Exactly DMAX busy cycles drains normally
    txn(1, 32'h8000_9200, 0, 10'h020, 0, 0, 32'h0, 0, 0, DMAX);

    for (int i = 0; i < 60; i++) begin
      exc_handler = $urandom; int_handler = $urandom;
      tlb_refill_handler = $urandom; epc = $urandom;
      r_pc = $urandom; r_pc[1:0] = 2'b00;
      r_dva = $urandom;
      r_exc = ($urandom_range(0, 3) == 0) ? 10'h0 : (10'($urandom) & 10'($urandom) & 10'($urandom));
      txn($urandom_range(0, 7) != 0, r_pc, 1'($urandom), r_exc, 1'($urandom), 1'($urandom),
          r_dva, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7));
    end

    // Reset in the middle of a drain aborts the sequence
    @(negedge clk);
    mem_valid = 1; mem_exc = 10'h020; mem_eret = 0; interrupt_pending = 0; mem_busy = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_abort_stall", stall, 1);
    resetn = 1'b0; mem_valid = 1'b0;
    tout_model = 1'b0;
    #1;
    chk("abort_outputs", {en_exp_o, clear_exl, redirect_valid, stall, flush, drain_timeout}, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk("post_abort_quiet", {en_exp_o, clear_exl, redirect_valid, stall}, 0);
    end
    mem_busy = 1'b0;
    txn(1, 32'h8000_A000, 0, 10'h020, 0, 0, 32'h0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
